// File: rtl/alu_operand_stage.sv
// Y86-64 execute-stage front end: selects ALU operands A/B and the function code
// from decoded fields and registers them for the ALU.
module alu_operand_stage #(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [1:0]       alufun,
  output logic             fun_err
);

  // Negative step is formed by subtraction so it stays sign-correct at any WIDTH.
  localparam logic [WIDTH-1:0] STEP_POS = WIDTH'(STACK_STEP);
  localparam logic [WIDTH-1:0] STEP_NEG = {WIDTH{1'b0}} - STEP_POS;

  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic [1:0]       alufun_s;
  logic             fun_err_s;

  // Operand A selection.
  always_comb begin
    alu_a_s = {WIDTH{1'b0}};
    case (icode)
      4'h2, 4'h6:       alu_a_s = valA;
      4'h3, 4'h4, 4'h5: alu_a_s = valC;
      4'h8, 4'hA:       alu_a_s = STEP_NEG;
      4'h9, 4'hB:       alu_a_s = STEP_POS;
      default:          alu_a_s = {WIDTH{1'b0}};
    endcase
  end

  // Operand B selection.
  always_comb begin
    alu_b_s = {WIDTH{1'b0}};
    case (icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b_s = valB;
      default:                                  alu_b_s = {WIDTH{1'b0}};
    endcase
  end

  // Function select; only OPq passes ifun through, out-of-range ifun flags an error.
  always_comb begin
    alufun_s  = 2'd0;
    fun_err_s = 1'b0;
    if (icode == 4'h6) begin
      if (ifun[3:2] == 2'b00) begin
        alufun_s  = ifun[1:0];
        fun_err_s = 1'b0;
      end else begin
        alufun_s  = 2'd0;
        fun_err_s = 1'b1;
      end
    end else begin
      alufun_s  = 2'd0;
      fun_err_s = 1'b0;
    end
  end

  // Output registers with capture enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluA    <= {WIDTH{1'b0}};
      aluB    <= {WIDTH{1'b0}};
      alufun  <= 2'd0;
      fun_err <= 1'b0;
    end else if (en) begin
      aluA    <= alu_a_s;
      aluB    <= alu_b_s;
      alufun  <= alufun_s;
      fun_err <= fun_err_s;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

  localparam int WIDTH = 64;
  localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [WIDTH-1:0] valC;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [1:0]       alufun;
  logic             fun_err;

  int vectors;
  int miscompares;

  alu_operand_stage #(.WIDTH(WIDTH), .STACK_STEP(8)) dut (
    .clk(clk), .rst(rst), .en(en), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC),
    .aluA(aluA), .aluB(aluB), .alufun(alufun), .fun_err(fun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] f, input logic e);
    vectors++;
    assert ({aluA, aluB, alufun, fun_err} === {a, b, f, e}) else begin
      miscompares++;
      $error("FAIL %s: observed aluA=%h aluB=%h alufun=%0d fun_err=%0b expected aluA=%h aluB=%h alufun=%0d fun_err=%0b",
             tag, aluA, aluB, alufun, fun_err, a, b, f, e);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic drive(input logic e, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    @(negedge clk);
    en = e; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; en = 1'b0; icode = 4'h0; ifun = 4'h0;
    valA = 64'd0; valB = 64'd0; valC = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'd0, 64'd0, 2'd0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'h6, 4'h2, 64'd33, 64'd44, 64'd55);
    check("load_nonzero", 64'd33, 64'd44, 2'd2, 1'b0);
    drive(1'b1, 4'h6, 4'h9, 64'd33, 64'd44, 64'd55);
    check("load_err", 64'd33, 64'd44, 2'd0, 1'b1);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 64'd0, 64'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd12, 64'd99);
    check("opq_sub", 64'd5, 64'd12, 2'd1, 1'b0);
    drive(1'b1, 4'h6, 4'h3, 64'd5, 64'd12, 64'd99);
    check("opq_xor", 64'd5, 64'd12, 2'd3, 1'b0);
    drive(1'b1, 4'h6, 4'h7, 64'd5, 64'd12, 64'd99);
    check("opq_bad", 64'd5, 64'd12, 2'd0, 1'b1);
    drive(1'b1, 4'h6, 4'h4, 64'd6, 64'd7, 64'd99);
    check("opq_bad4", 64'd6, 64'd7, 2'd0, 1'b1);
    drive(1'b1, 4'h2, 4'h0, 64'h1234, 64'h5678, 64'h9ABC);
    check("rrmovq", 64'h1234, 64'd0, 2'd0, 1'b0);

    drive(1'b1, 4'h3, 4'h0, 64'd1, 64'd77, 64'd100);
    check("irmovq", 64'd100, 64'd0, 2'd0, 1'b0);
    drive(1'b1, 4'h5, 4'h0, 64'd1, 64'd40, 64'd16);
    check("mrmovq", 64'd16, 64'd40, 2'd0, 1'b0);
    drive(1'b1, 4'h4, 4'h2, 64'd1, 64'd41, 64'd17);
    check("rmmovq", 64'd17, 64'd41, 2'd0, 1'b0);

    drive(1'b1, 4'hA, 4'h0, 64'd3, 64'h100, 64'd9);
    check("pushq", NEG8, 64'h100, 2'd0, 1'b0);
    drive(1'b1, 4'hB, 4'h0, 64'd3, 64'h100, 64'd9);
    check("popq", 64'd8, 64'h100, 2'd0, 1'b0);
    drive(1'b1, 4'h8, 4'h0, 64'd3, 64'h100, 64'd9);
    check("call", NEG8, 64'h100, 2'd0, 1'b0);
    drive(1'b1, 4'h9, 4'h0, 64'd3, 64'h100, 64'd9);
    check("ret", 64'd8, 64'h100, 2'd0, 1'b0);

    // Hold: en low, all inputs change, outputs keep the ret result.
    drive(1'b0, 4'h6, 4'h3, 64'hAAAA, 64'hBBBB, 64'hCCCC);
    check("hold_1", 64'd8, 64'h100, 2'd0, 1'b0);
    drive(1'b0, 4'h6, 4'h8, 64'h1111, 64'h2222, 64'h3333);
    check("hold_2", 64'd8, 64'h100, 2'd0, 1'b0);

    drive(1'b1, 4'h0, 4'h3, 64'h11, 64'h22, 64'h33);
    check("halt", 64'd0, 64'd0, 2'd0, 1'b0);
    drive(1'b1, 4'h6, 4'h2, 64'h44, 64'h55, 64'h66);
    check("opq_and", 64'h44, 64'h55, 2'd2, 1'b0);
    drive(1'b1, 4'h1, 4'h3, 64'h11, 64'h22, 64'h33);
    check("nop", 64'd0, 64'd0, 2'd0, 1'b0);
    drive(1'b1, 4'h7, 4'h2, 64'h11, 64'h22, 64'h33);
    check("jxx", 64'd0, 64'd0, 2'd0, 1'b0);
    drive(1'b1, 4'hC, 4'h1, 64'h11, 64'h22, 64'h33);
    check("icode_c", 64'd0, 64'd0, 2'd0, 1'b0);
    drive(1'b1, 4'hF, 4'hF, 64'h11, 64'h22, 64'h33);
    check("icode_f", 64'd0, 64'd0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
